// File: rtl/c_fetch_align_buf.sv
`default_nettype none
// ============================================================================
// Module   : c_fetch_align_buf
// Purpose  : Instruction fetch unit with a halfword alignment FIFO. Fetches
//            32-bit words from instruction memory (one outstanding read at a
//            time). It splits each word into 16-bit parcels and presents
//            them, one parcel at a time, to a 16-bit decode stage with the
//            byte PC of each parcel. Redirects flush the FIFO. A redirect
//            also drops any read that is already granted.
// Ports    : risc_clk/risc_rst   - clock, synchronous active-high reset
//            imem_req/imem_addr  - word-aligned read request
//            imem_gnt            - request accepted
//            imem_rvalid/rdata   - read response (little-endian halfwords)
//            redirect/redirect_pc- flush and refetch from new PC
//            instr_valid/ready   - parcel handshake toward decode
//            instruction/instr_pc- head parcel and its byte address
// Revision : 1.0 - initial release
// ============================================================================
module c_fetch_align_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        risc_clk,
  input  logic        risc_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);
  localparam logic [31:0]     c_reset_pc  = {RESET_PC[31:1], 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_out_pc;
  logic [c_cw-1:0]   r_count;
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic              r_drop;
  logic [15:0]       r_mem [DEPTH];

  logic [c_cw-1:0]   w_free;
  logic              w_accept;
  logic              w_pop;
  logic [1:0]        w_push_n;
  logic [15:0]       w_first;
  logic [c_aw-1:0]   w_wr_ptr_p1;
  logic [31:0]       w_redirect_pc;
  logic              w_unused_bit0;

  // Bit 0 of the redirect target carries no information for halfword PCs.
  assign w_unused_bit0 = redirect_pc[0];
  assign w_redirect_pc = {redirect_pc[31:1], 1'b0};

  assign w_free      = c_depth_cnt - r_count;
  assign w_wr_ptr_p1 = r_wr_ptr + c_aw'(1);

  // A response is kept only if it belongs to the current fetch stream:
  // neither marked for dropping nor racing a redirect in the same cycle.
  assign w_accept = (r_state == S_WAIT) && imem_rvalid && !r_drop && !redirect;

  // An odd-halfword fetch PC means the low halfword lies before the
  // target, so only the upper halfword of the word is useful.
  assign w_push_n = !w_accept     ? 2'd0 :
                    r_fetch_pc[1] ? 2'd1 : 2'd2;
  assign w_first  = r_fetch_pc[1] ? imem_rdata[31:16] : imem_rdata[15:0];

  assign instr_valid = (r_count != '0);
  assign instruction = r_mem[r_rd_ptr];
  assign instr_pc    = r_out_pc;
  assign w_pop       = instr_valid && instr_ready && !redirect;

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = {r_fetch_pc[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Issue only when the whole word fits, so the FIFO cannot overflow.
        if (!redirect && (w_free >= c_cw'(2))) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end else if (redirect) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A granted read cannot be cancelled. When a redirect arrives after the
  // grant, remember to throw away the response that is still on its way.
  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      r_drop <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect && imem_gnt) begin
            r_drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_drop <= 1'b0;
          end else if (redirect) begin
            r_drop <= 1'b1;
          end
        end
        default: r_drop <= r_drop;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Program counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      r_fetch_pc <= c_reset_pc;
      r_out_pc   <= c_reset_pc;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_out_pc   <= w_redirect_pc;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= {r_fetch_pc[31:2] + 30'd1, 2'b00};
      end
      if (w_pop) begin
        r_out_pc <= r_out_pc + 32'd2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Halfword FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge risc_clk) begin
    if (risc_rst || redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count  <= r_count + c_cw'(w_push_n) - c_cw'(w_pop);
      r_wr_ptr <= r_wr_ptr + c_aw'(w_push_n);
      r_rd_ptr <= r_rd_ptr + c_aw'(w_pop);
    end
  end

  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (w_push_n != 2'd0) begin
      r_mem[r_wr_ptr] <= w_first;
      if (w_push_n == 2'd2) begin
        r_mem[w_wr_ptr_p1] <= imem_rdata[31:16];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c_fetch_align_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_fetch_align_buf
// Purpose  : Directed self-checking bench for c_fetch_align_buf. A small
//            instruction-memory responder grants each request and returns
//            data one cycle later. Expected values are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_fetch_align_buf;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [31:0] instr_pc;

  int n_checks;
  int n_fail;

  c_fetch_align_buf #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .risc_clk    (clk),
    .risc_rst    (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, grant it immediately
  // and return the data on the following cycle.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    for (int i = 0; i < 20 && !imem_req; i++) begin
      tick();
    end
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check_eq({tag, "_addr"}, imem_addr, exp_addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, instruction}, 32'h0);
    check_eq("rst_req",   {31'd0, imem_req},    32'd0);
    check_eq("rst_pc",    instr_pc,             32'h0);

    // Aligned word: two parcels, then the next fetch at 4
    serve("f0", 32'h0, 32'hABCD_1234);
    check_eq("f0_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("f0_instr", {16'd0, instruction}, 32'h1234);
    check_eq("f0_pc",    instr_pc,             32'h0);
    pop_one();
    check_eq("f0_instr2", {16'd0, instruction}, 32'hABCD);
    check_eq("f0_pc2",    instr_pc,             32'h2);
    check_eq("f0_nreq",   {31'd0, imem_req},    32'd1);
    check_eq("f0_naddr",  imem_addr,            32'h4);

    // Redirect while requesting without grant: request withdrawn, FIFO flushed
    do_redirect(32'h0000_0102);
    check_eq("rd_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rd_req",   {31'd0, imem_req},    32'd0);
    serve("rd", 32'h100, 32'h5555_AAAA);
    check_eq("rd_instr", {16'd0, instruction}, 32'h5555);
    check_eq("rd_pc",    instr_pc,             32'h102);

    // Fill all four slots with decode stalled
    do_redirect(32'h0000_0300);
    serve("fa", 32'h300, 32'h2222_1111);
    serve("fb", 32'h304, 32'h4444_3333);
    tick(); tick(); tick();
    check_eq("full_req",   {31'd0, imem_req},    32'd0);
    check_eq("full_instr", {16'd0, instruction}, 32'h1111);
    check_eq("full_pc",    instr_pc,             32'h300);
    pop_one();
    check_eq("p1_instr", {16'd0, instruction}, 32'h2222);
    check_eq("p1_pc",    instr_pc,             32'h302);
    tick();
    check_eq("p1_req",   {31'd0, imem_req},    32'd0);
    pop_one();
    check_eq("p2_instr", {16'd0, instruction}, 32'h3333);
    tick();
    check_eq("p2_req",   {31'd0, imem_req},    32'd1);
    check_eq("p2_addr",  imem_addr,            32'h308);

    // Redirect while waiting: the late response is dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_redirect(32'h0000_0200);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check_eq("drop_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("drop_req",   {31'd0, imem_req},    32'd0);
    tick();
    check_eq("drop_nreq",  {31'd0, imem_req},    32'd1);
    check_eq("drop_naddr", imem_addr,            32'h200);

    // Address wrap at the top of memory
    do_redirect(32'hFFFF_FFFC);
    serve("wr", 32'hFFFF_FFFC, 32'h8765_4321);
    check_eq("wr_instr", {16'd0, instruction}, 32'h4321);
    check_eq("wr_pc",    instr_pc,             32'hFFFF_FFFC);
    pop_one();
    check_eq("wr_instr2", {16'd0, instruction}, 32'h8765);
    check_eq("wr_pc2",    instr_pc,             32'hFFFF_FFFE);
    check_eq("wr_naddr",  imem_addr,            32'h0);
    pop_one();
    check_eq("wr_empty", {31'd0, instr_valid}, 32'd0);
    check_eq("wr_pc3",   instr_pc,             32'h0);

    // Ready with an empty FIFO: no pop, PC unchanged
    pop_one();
    check_eq("emp_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("emp_pc",    instr_pc,             32'h0);

    // Reset during WAIT, then a stray response
    do_redirect(32'h0000_0400);
    tick();
    check_eq("rw_addr", imem_addr, 32'h400);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check_eq("rw_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rw_instr", {16'd0, instruction}, 32'h0);
    check_eq("rw_req",   {31'd0, imem_req},    32'd1);
    check_eq("rw_raddr", imem_addr,            32'h0);
    check_eq("rw_pc",    instr_pc,             32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
